fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end that decouples the core from instruction-memory latency. It sits between the instruction memory port and the decode stage and replaces the single-register fetch stage with a request/response memory handshake, multiple outstanding fetches and a DEPTH-entry prefetch queue. Redirects from execute flush the queue and drop stale in-flight responses. A decode stall holds the queue head without losing fetched instructions.

---
 rtl/fetch_queue_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_queue_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction-fetch front end between the instruction memory port and decode.
//   Issues fetch requests with multiple outstanding transactions, tags in-order
//   responses with their PC and buffers them in a DEPTH-entry prefetch queue.
//   A redirect flushes the queue and turns every in-flight request into one
//   whose response is discarded on arrival.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   stall                        decode stall, holds the queue head
//   redirect_valid/addr          taken branch/jump from execute
//   imem_req_valid/addr/ready    fetch request handshake
//   imem_resp_valid/data         in-order fetch responses
//   dec_valid/inst/pc            queue head toward decode (NOP / 0 when empty)
module fetch_queue_unit #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INST_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [INST_W-1:0]  NOP      = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              dec_valid,
  output logic [INST_W-1:0] dec_inst,
  output logic [ADDR_W-1:0] dec_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rpc_rd_q, rpc_rd_d;
  logic [PTR_W-1:0]  rpc_wr_q, rpc_wr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  live_q, live_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  // Queue storage and the PC tag FIFO for live requests; no reset needed,
  // entries are only read once count/live say they were written.
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] qpc_mem  [DEPTH];
  logic [ADDR_W-1:0] rpc_mem  [DEPTH];

  logic [SUM_W-1:0]  credit_sum;
  logic              credit_ok;
  logic              accept;
  logic              resp_keep;
  logic              resp_drop;
  logic              pop;

  // Every accepted request reserves a queue slot until its response either
  // lands in the queue and is popped, or is discarded. This is what keeps the
  // queue from ever overflowing, even with the memory at full latency.
  assign credit_sum = SUM_W'(count_q) + SUM_W'(live_q) + SUM_W'(drop_q);
  assign credit_ok  = credit_sum < SUM_W'(DEPTH);

  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // Responses are in order, so the oldest outstanding ones are the stale ones.
  assign resp_drop = imem_resp_valid && (drop_q != '0);
  assign resp_keep = imem_resp_valid && (drop_q == '0) && !redirect_valid;

  assign dec_valid = (count_q != '0);
  assign dec_inst  = dec_valid ? inst_mem[rd_ptr_q] : NOP;
  assign dec_pc    = dec_valid ? qpc_mem[rd_ptr_q]  : '0;
  assign pop       = dec_valid && !stall && !redirect_valid;

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rpc_rd_d = rpc_rd_q;
    rpc_wr_d = rpc_wr_q;
    count_d  = count_q;
    live_d   = live_q;
    drop_d   = drop_q;

    if (redirect_valid) begin
      // Everything outstanding becomes stale; a response arriving in this
      // very cycle is already consumed, so it is not counted again.
      pc_d     = redirect_addr;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      rpc_rd_d = '0;
      rpc_wr_d = '0;
      count_d  = '0;
      live_d   = '0;
      drop_d   = live_q + drop_q - CNT_W'(imem_resp_valid);
    end else begin
      if (accept) begin
        pc_d     = pc_q + ADDR_W'(4);
        rpc_wr_d = rpc_wr_q + PTR_W'(1);
      end
      if (resp_keep) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        rpc_rd_d = rpc_rd_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (resp_drop) begin
        drop_d = drop_q - CNT_W'(1);
      end
      live_d  = live_q + CNT_W'(accept) - CNT_W'(resp_keep);
      count_d = count_q + CNT_W'(resp_keep) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rpc_rd_q <= '0;
      rpc_wr_q <= '0;
      count_q  <= '0;
      live_q   <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rpc_rd_q <= rpc_rd_d;
      rpc_wr_q <= rpc_wr_d;
      count_q  <= count_d;
      live_q   <= live_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rpc_mem[rpc_wr_q] <= pc_q;
    end
    if (resp_keep && !rst) begin
      inst_mem[wr_ptr_q] <= imem_resp_data;
      qpc_mem[wr_ptr_q]  <= rpc_mem[rpc_rd_q];
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: an in-order variable-latency memory model plus
// a reference of what decode must see, kept as plain queues of addresses.
module tb_fetch_queue_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;

  fetch_queue_unit #(
    .ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          rdy;
    bit          stale;
  } mitem_t;

  mitem_t      memq[$];     // accepted, not yet answered
  logic [31:0] exp_q[$];    // PCs that decode must see, in order
  logic [31:0] exp_req;     // address the next request must carry
  bit          hold_pending;
  logic [31:0] held_addr;
  int          lat;
  bit          gaps;
  int          cyc;
  int          n_tests;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E69;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: inputs other than the memory response are already set.
  task automatic tick();
    mitem_t      it;
    bit          exp_valid;
    bit          exp_rv;
    bit          keep;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (!rst && memq.size() > 0 && memq[0].rdy <= cyc &&
        (!gaps || $urandom_range(0, 3) != 0)) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(memq[0].addr);
    end
    @(negedge clk);

    exp_valid = exp_q.size() != 0;
    chk("dec_valid", 64'(dec_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("dec_pc", 64'(dec_pc), 64'(exp_q[0]));
      chk("dec_inst", 64'(dec_inst), 64'(mem_word(exp_q[0])));
    end else begin
      chk("empty_inst", 64'(dec_inst), 64'(NOP));
      chk("empty_pc", 64'(dec_pc), 64'h0);
    end
    exp_rv = !rst && !redirect_valid && (exp_q.size() + memq.size() < DEPTH);
    chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (imem_req_valid) chk("req_addr", 64'(imem_req_addr), 64'(exp_req));
    if (hold_pending && !rst && !redirect_valid)
      chk("req_hold", 64'(imem_req_addr), 64'(held_addr));

    if (rst) begin
      exp_q.delete();
      memq.delete();
      exp_req      = RESET_PC;
      hold_pending = 1'b0;
    end else begin
      keep = 1'b0;
      if (imem_resp_valid) begin
        it   = memq.pop_front();
        keep = !it.stale && !redirect_valid;
      end
      if (redirect_valid) begin
        exp_q.delete();
        foreach (memq[i]) memq[i].stale = 1'b1;
        exp_req      = redirect_addr;
        hold_pending = 1'b0;
      end else begin
        if (exp_valid && !stall) void'(exp_q.pop_front());
        if (keep) exp_q.push_back(it.addr);
        hold_pending = exp_rv && !imem_req_ready;
        held_addr    = exp_req;
        if (exp_rv && imem_req_ready) begin
          memq.push_back('{addr: exp_req, rdy: cyc + lat, stale: 1'b0});
          exp_req = exp_req + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] first_pc;
    logic [31:0] second_pc;
    int          got;

    n_tests = 0; n_fail = 0; cyc = 0;
    lat = 1; gaps = 1'b0;
    exp_req = RESET_PC; hold_pending = 1'b0; held_addr = '0;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    @(posedge clk);
    #1;
    tick();
    tick();

    // Streaming with a 1-cycle memory: one instruction per cycle from cycle 2.
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      #1;
      if (k == 0) begin
        chk("rst_req_valid", 64'(imem_req_valid), 64'h1);
        chk("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
      end
      if (k >= 2) begin
        chk("thru_valid", 64'(dec_valid), 64'h1);
        chk("thru_pc", 64'(dec_pc), 64'(RESET_PC + 32'(4 * (k - 2))));
      end
      tick();
    end

    // Decode stall: queue fills, requests stop, then drains without gaps.
    stall = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    #1;
    chk("full_noreq", 64'(imem_req_valid), 64'h0);
    chk("full_valid", 64'(dec_valid), 64'h1);
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_valid", 64'(dec_valid), 64'h1);
      tick();
    end

    // 3-cycle memory, redirect with responses in flight.
    lat = 3;
    for (int k = 0; k < 20 && memq.size() != 3; k++) tick();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h100;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("redir_empty", 64'(dec_valid), 64'h0);
    chk("redir_addr", 64'(imem_req_addr), 64'h100);
    first_pc = 32'hDEAD; second_pc = 32'hDEAD; got = 0;
    for (int k = 0; k < 30 && got < 2; k++) begin
      #1;
      if (dec_valid) begin
        if (got == 0) first_pc = dec_pc;
        else second_pc = dec_pc;
        got++;
      end
      tick();
    end
    chk("redir_first", 64'(first_pc), 64'h100);
    chk("redir_second", 64'(second_pc), 64'h104);

    // Redirect while stalled, with a response arriving in the same cycle.
    lat = 2;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h2000;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    stall = 1'b0;
    for (int k = 0; k < 10; k++) tick();

    // Reset with a full queue.
    lat = 1;
    stall = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = 1'b0;
    #1;
    chk("rst_full_valid", 64'(dec_valid), 64'h0);
    chk("rst_full_inst", 64'(dec_inst), 64'(NOP));
    chk("rst_full_addr", 64'(imem_req_addr), 64'(RESET_PC));
    for (int k = 0; k < 6; k++) tick();

    // Randomized traffic.
    gaps = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) lat = $urandom_range(1, 4);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_addr  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      rst            = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0; stall = 1'b0; imem_req_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
